// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Optional subtract mode is enabled with `define BCD_ADDER_SUB_EN.
package bcd_pkg;

  localparam int unsigned DIGIT_W  = 4;
  localparam int unsigned BCD_MAX  = 9;
  localparam int unsigned BCD_CORR = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Nines' complement of one BCD digit; a non-BCD digit maps to a non-BCD digit.
  function automatic logic [DIGIT_W-1:0] nines(input logic [DIGIT_W-1:0] d);
    return DIGIT_W'(BCD_MAX) - d;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add with decimal correction and operand validity flag.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] x,
  input  logic [DIGIT_W-1:0] y,
  input  logic               ci,
  output logic [DIGIT_W-1:0] s,
  output logic               co,
  output logic               invalid
);

  logic [DIGIT_W:0] bin;

  always_comb begin
    bin     = (DIGIT_W+1)'(x) + (DIGIT_W+1)'(y) + (DIGIT_W+1)'(ci);
    invalid = (x > DIGIT_W'(BCD_MAX)) || (y > DIGIT_W'(BCD_MAX));
    co      = bin > (DIGIT_W+1)'(BCD_MAX);
    s       = co ? DIGIT_W'(bin + (DIGIT_W+1)'(BCD_CORR)) : bin[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_adder_serial.sv
// Digit-serial BCD adder: one digit per cycle, LSD first, fixed DIGITS+1 cycle latency.
// Define BCD_ADDER_SUB_EN to add the sub port (a - b via nines' complement).
module bcd_adder_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [DIGIT_W*DIGITS-1:0]   a,
  input  logic [DIGIT_W*DIGITS-1:0]   b,
  input  logic                        cin,
`ifdef BCD_ADDER_SUB_EN
  input  logic                        sub,
`endif
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*DIGITS-1:0]   sum,
  output logic                        cout,
  output logic                        error
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = $clog2(DIGITS) + 1;

  state_t             state;
  logic [W-1:0]       a_r;
  logic [W-1:0]       b_r;
  logic [W-1:0]       acc;
  logic               carry_r;
  logic               err_r;
  logic [IDX_W-1:0]   idx;
  logic [DIGIT_W-1:0] y_dig_c;
  logic [DIGIT_W-1:0] dig_s_c;
  logic               dig_co_c;
  logic               dig_inv_c;

`ifdef BCD_ADDER_SUB_EN
  logic sub_r;

  always_comb begin
    y_dig_c = b_r[DIGIT_W-1:0];
    if (sub_r) y_dig_c = nines(b_r[DIGIT_W-1:0]);
  end
`else
  always_comb begin
    y_dig_c = b_r[DIGIT_W-1:0];
  end
`endif

  bcd_digit_add u_digit (
    .x       (a_r[DIGIT_W-1:0]),
    .y       (y_dig_c),
    .ci      (carry_r),
    .s       (dig_s_c),
    .co      (dig_co_c),
    .invalid (dig_inv_c)
  );

  // Operands shift right so the current digit is always at [3:0]; results fill acc from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      carry_r <= 1'b0;
      err_r   <= 1'b0;
      idx     <= '0;
`ifdef BCD_ADDER_SUB_EN
      sub_r   <= 1'b0;
`endif
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      error   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r     <= a;
            b_r     <= b;
            acc     <= '0;
            idx     <= '0;
            err_r   <= 1'b0;
`ifdef BCD_ADDER_SUB_EN
            sub_r   <= sub;
            carry_r <= sub | cin;
`else
            carry_r <= cin;
`endif
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (idx == IDX_W'(DIGITS)) begin
            sum   <= err_r ? '0 : acc;
            cout  <= carry_r & ~err_r;
            error <= err_r;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            acc     <= (acc >> DIGIT_W) | (W'(dig_s_c) << (W - DIGIT_W));
            carry_r <= dig_co_c;
            err_r   <= err_r | dig_inv_c;
            a_r     <= a_r >> DIGIT_W;
            b_r     <= b_r >> DIGIT_W;
            idx     <= idx + IDX_W'(1);
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_adder_serial.sv
// Self-checking bench for bcd_adder_serial: decimal-arithmetic reference model plus directed cases.
module tb_bcd_adder_serial;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         busy;
  logic         done;
  logic         cout;
  logic         error;
  logic [W-1:0] sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_adder_serial #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef BCD_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .error (error)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: convert to integers, do decimal arithmetic, convert back. Returns {error, cout, sum}.
  function automatic logic [W+1:0] ref_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                          input logic xc, input logic xs);
    longint unsigned av, bv, p, tot, s;
    bit bad;
    logic [W-1:0] enc;
    av = 0; bv = 0; p = 1; bad = 0; enc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (xa[i*4 +: 4] > 4'd9 || xb[i*4 +: 4] > 4'd9) bad = 1;
      av = av * 10 + longint'(xa[i*4 +: 4]);
      bv = bv * 10 + longint'(xb[i*4 +: 4]);
      p  = p * 10;
    end
    if (bad) return {2'b10, {W{1'b0}}};
    tot = xs ? av + (p - 1 - bv) + 1 : av + bv + longint'(xc);
    s = tot % p;
    for (int i = 0; i < int'(DIGITS); i++) begin
      enc[i*4 +: 4] = 4'(s % 10);
      s = s / 10;
    end
    return {1'b0, tot >= p, enc};
  endfunction

  // Timing model: cnt counts edges since the accepted start; outputs update when done is due.
  int           cnt  = 0;
  logic [W+1:0] pend = '0;
  logic [W+1:0] held = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  = 0;
      held = '0;
    end else if (cnt == 0) begin
      if (start) begin
        pend = ref_op(a, b, cin, sub);
        cnt  = 1;
      end
    end else begin
      cnt++;
      if (cnt == int'(DIGITS) + 2) held = pend;
      else if (cnt > int'(DIGITS) + 2) cnt = 0;
    end
  end

  always @(negedge clk) begin
    check("busy",  busy,  cnt != 0);
    check("done",  done,  cnt == int'(DIGITS) + 2);
    check("sum",   sum,   held[W-1:0]);
    check("cout",  cout,  held[W]);
    check("error", error, held[W+1]);
  end

  task automatic run_op(input string name, input bit now,
                        input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic ee);
    int lat;
    if (!now) @(negedge clk);
    a = ta; b = tb_v; cin = tc; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(DIGITS + 1));
    check({name, "_sum"},   sum,   es);
    check({name, "_cout"},  cout,  ec);
    check({name, "_error"}, error, ee);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    logic [W-1:0] got;
    logic [W-1:0] ra, rb;

    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_error", error, 0);

    check("model_1234_5678", ref_op(16'h1234, 16'h5678, 1'b0, 1'b0), {2'b00, 16'h6912});
    check("model_9999_0001", ref_op(16'h9999, 16'h0001, 1'b0, 1'b0), {2'b01, 16'h0000});
    check("model_9999_9999", ref_op(16'h9999, 16'h9999, 1'b1, 1'b0), {2'b01, 16'h9999});
    check("model_12A4", ref_op(16'h12A4, 16'h0001, 1'b0, 1'b0), {2'b10, 16'h0000});
    check("model_sub_5000", ref_op(16'h5000, 16'h1234, 1'b0, 1'b1), {2'b01, 16'h3766});
    check("model_sub_1234", ref_op(16'h1234, 16'h5000, 1'b0, 1'b1), {2'b00, 16'h6234});

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("add_basic", 1'b0, 16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0);
    run_op("wrap",      1'b0, 16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("wrap_cin",  1'b0, 16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0);
    run_op("bad_digit", 1'b0, 16'h12A4, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);

    // A second start while busy must not disturb the captured operands.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    a = 16'h4444; b = 16'h5555; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; got = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        got = sum;
      end
      @(negedge clk);
    end
    check("busy_start_pulses", 64'(pulses), 64'd1);
    check("busy_start_sum", got, 16'h3333);

    // start during the done cycle is ignored.
    run_op("pre_done", 1'b0, 16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
    a = 16'h7777; b = 16'h1111; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start_ignored", busy, 0);

    // Reset mid-run aborts with no done pulse.
    @(negedge clk);
    a = 16'h1000; b = 16'h2000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 1'b1, 16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);

`ifdef BCD_ADDER_SUB_EN
    run_op("sub_pos", 1'b0, 16'h5000, 16'h1234, 1'b1, 1'b1, 16'h3766, 1'b1, 1'b0);
    run_op("sub_neg", 1'b0, 16'h1234, 16'h5000, 1'b0, 1'b1, 16'h6234, 1'b0, 1'b0);
    sub = 1'b0;
`endif

    // Random traffic, including starts while busy; the compare process checks every cycle.
    for (int n = 0; n < 150; n++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      for (int d = 0; d < int'(DIGITS); d++) begin
        ra[d*4 +: 4] = 4'($urandom_range(0, 9));
        rb[d*4 +: 4] = 4'($urandom_range(0, 9));
      end
      if ($urandom_range(0, 15) == 0) ra[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) rb[$urandom_range(0, DIGITS - 1)*4 +: 4] = 4'($urandom_range(0, 15));
      a = ra; b = rb; cin = 1'($urandom_range(0, 1));
`ifdef BCD_ADDER_SUB_EN
      sub = 1'($urandom_range(0, 1));
`endif
      start = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      start = 1'b0;
    end
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
